// File: rtl/rename_pkg.sv
// Shared defaults, register-index typedefs and the map-table snapshot layout
// for the register rename block.
package rename_pkg;

  localparam int ARCH_REGS_DEF  = 32;
  localparam int PHYS_REGS_DEF  = 64;
  localparam int CKPT_DEPTH_DEF = 4;

  localparam int AW_DEF = $clog2(ARCH_REGS_DEF);
  localparam int PW_DEF = $clog2(PHYS_REGS_DEF);
  localparam int CW_DEF = $clog2(CKPT_DEPTH_DEF);

  typedef logic [AW_DEF-1:0] arch_reg_t;
  typedef logic [PW_DEF-1:0] phys_reg_t;
  typedef logic [CW_DEF-1:0] ckpt_id_t;

  // One branch checkpoint: full map plus the free-list read pointer.
  typedef struct packed {
    phys_reg_t [ARCH_REGS_DEF-1:0] map;
    logic [PW_DEF:0]               head;
  } map_table_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical register numbers; pointers carry a wrap bit
// so a full list and an empty list are distinguishable.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  input  logic          restore,
  input  logic [PW:0]   restore_head,
  output logic [PW-1:0] head_data,
  output logic [PW:0]   head_ptr,
  output logic [PW:0]   count
);

  logic [PW:0]   head_reg;
  logic [PW:0]   tail_reg;
  logic [PW-1:0] mem [PHYS_REGS];

  assign head_data = mem[head_reg[PW-1:0]];
  assign head_ptr  = head_reg;
  assign count     = tail_reg - head_reg;

  // Restore wins over pop; the rename side never pops during a recovery.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg <= '0;
      tail_reg <= (PW+1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      if (restore)
        head_reg <= restore_head;
      else if (pop)
        head_reg <= head_reg + 1'b1;
      if (push)
        tail_reg <= tail_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHYS_REGS; i++)
        mem[i] <= (i < PHYS_REGS - ARCH_REGS) ? PW'(i + ARCH_REGS) : '0;
    end else if (push) begin
      mem[tail_reg[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/rename_map_unit.sv
// Register rename: architectural-to-physical map, free-list allocation and
// branch checkpoints with in-order release and recovery to any live slot.
module rename_map_unit
  import rename_pkg::*;
#(
  parameter int ARCH_REGS  = ARCH_REGS_DEF,
  parameter int PHYS_REGS  = PHYS_REGS_DEF,
  parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(CKPT_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_ren_valid,
  output logic          o_ren_ready,
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_rt,
  input  logic [AW-1:0] i_rw,
  input  logic          i_uses_rw,
  input  logic          i_is_branch,
  output logic [PW-1:0] o_rs_phys,
  output logic [PW-1:0] o_rt_phys,
  output logic [PW-1:0] o_rw_phys,
  output logic [PW-1:0] o_old_rw_phys,
  output logic [CW-1:0] o_ckpt_id,
  input  logic          i_commit_valid,
  input  logic [PW-1:0] i_commit_free,
  input  logic          i_recover_valid,
  input  logic [CW-1:0] i_recover_id,
  input  logic          i_release_valid,
  output logic [PW:0]   o_free_count,
  output logic          o_ckpt_full
);

  typedef struct packed {
    logic [ARCH_REGS-1:0][PW-1:0] map;
    logic [PW:0]                  head;
  } ckpt_t;

  function automatic logic [CW-1:0] ckpt_incr(input logic [CW-1:0] p);
    return (int'(p) == CKPT_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CW:0] ckpt_dist(input logic [CW-1:0] from, input logic [CW-1:0] to);
    if (to >= from)
      return {1'b0, to} - {1'b0, from};
    else
      return {1'b0, to} + (CW+1)'(CKPT_DEPTH) - {1'b0, from};
  endfunction

  logic [ARCH_REGS-1:0][PW-1:0] map_reg;
  logic [ARCH_REGS-1:0][PW-1:0] map_next;
  ckpt_t                        ckpt_mem [CKPT_DEPTH];
  ckpt_t                        rec_entry;
  logic [CW-1:0]                ckpt_head_reg, ckpt_head_next;
  logic [CW-1:0]                ckpt_tail_reg, ckpt_tail_next;
  logic [CW:0]                  ckpt_count_reg, ckpt_count_next;

  logic          alloc_needed, accept, alloc, take_ckpt, fl_push;
  logic [PW-1:0] fl_head_data;
  logic [PW:0]   fl_head_ptr, fl_count, snap_head;

  assign alloc_needed = i_uses_rw && (i_rw != '0);
  assign o_ckpt_full  = (ckpt_count_reg == (CW+1)'(CKPT_DEPTH));
  // Readiness uses registered state only; a same-cycle commit cannot help.
  assign o_ren_ready  = !i_recover_valid && (!alloc_needed || fl_count != '0)
                        && (!i_is_branch || !o_ckpt_full);
  assign accept       = i_ren_valid && o_ren_ready;
  assign alloc        = accept && alloc_needed;
  assign take_ckpt    = accept && i_is_branch;
  assign fl_push      = i_commit_valid && (i_commit_free != '0);

  assign o_rs_phys     = map_reg[i_rs];
  assign o_rt_phys     = map_reg[i_rt];
  assign o_old_rw_phys = map_reg[i_rw];
  assign o_rw_phys     = alloc_needed ? fl_head_data : map_reg[i_rw];
  assign o_ckpt_id     = ckpt_tail_reg;
  assign o_free_count  = fl_count;

  assign rec_entry = ckpt_mem[i_recover_id];
  assign snap_head = fl_head_ptr + (alloc ? (PW+1)'(1) : '0);

  rename_free_list #(
    .ARCH_REGS(ARCH_REGS),
    .PHYS_REGS(PHYS_REGS)
  ) u_free_list (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (fl_push),
    .push_data   (i_commit_free),
    .pop         (alloc),
    .restore     (i_recover_valid),
    .restore_head(rec_entry.head),
    .head_data   (fl_head_data),
    .head_ptr    (fl_head_ptr),
    .count       (fl_count)
  );

  always_comb begin
    map_next = map_reg;
    if (alloc)
      map_next[i_rw] = fl_head_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++)
        map_reg[i] <= PW'(i);
    end else if (i_recover_valid) begin
      map_reg <= rec_entry.map;
    end else begin
      map_reg <= map_next;
    end
  end

  // Snapshot includes the branch's own destination update.
  always_ff @(posedge clk) begin
    if (take_ckpt)
      ckpt_mem[ckpt_tail_reg] <= '{map: map_next, head: snap_head};
  end

  always_comb begin
    ckpt_head_next  = ckpt_head_reg;
    ckpt_tail_next  = ckpt_tail_reg;
    ckpt_count_next = ckpt_count_reg;
    if (i_recover_valid) begin
      ckpt_tail_next  = ckpt_incr(i_recover_id);
      ckpt_count_next = ckpt_dist(ckpt_head_reg, i_recover_id) + 1'b1;
    end else if (take_ckpt) begin
      ckpt_tail_next  = ckpt_incr(ckpt_tail_reg);
      ckpt_count_next = ckpt_count_reg + 1'b1;
    end
    // Recovery always leaves the restored slot live, so release can follow it.
    if (i_release_valid && (i_recover_valid || ckpt_count_reg != '0)) begin
      ckpt_head_next  = ckpt_incr(ckpt_head_reg);
      ckpt_count_next = ckpt_count_next - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ckpt_head_reg  <= '0;
      ckpt_tail_reg  <= '0;
      ckpt_count_reg <= '0;
    end else begin
      ckpt_head_reg  <= ckpt_head_next;
      ckpt_tail_reg  <= ckpt_tail_next;
      ckpt_count_reg <= ckpt_count_next;
    end
  end

endmodule

// File: tb/tb_rename_map_unit.sv
// Directed bench for rename_map_unit: reset state, allocation, free-list
// exhaustion and refill, checkpoint fill/release and recovery.
module tb_rename_map_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_ren_valid, o_ren_ready;
  logic [4:0] i_rs, i_rt, i_rw;
  logic       i_uses_rw, i_is_branch;
  logic [5:0] o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys;
  logic [1:0] o_ckpt_id;
  logic       i_commit_valid;
  logic [5:0] i_commit_free;
  logic       i_recover_valid;
  logic [1:0] i_recover_id;
  logic       i_release_valid;
  logic [6:0] o_free_count;
  logic       o_ckpt_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rename_map_unit dut (
    .clk(clk), .rst_n(rst_n),
    .i_ren_valid(i_ren_valid), .o_ren_ready(o_ren_ready),
    .i_rs(i_rs), .i_rt(i_rt), .i_rw(i_rw),
    .i_uses_rw(i_uses_rw), .i_is_branch(i_is_branch),
    .o_rs_phys(o_rs_phys), .o_rt_phys(o_rt_phys),
    .o_rw_phys(o_rw_phys), .o_old_rw_phys(o_old_rw_phys),
    .o_ckpt_id(o_ckpt_id),
    .i_commit_valid(i_commit_valid), .i_commit_free(i_commit_free),
    .i_recover_valid(i_recover_valid), .i_recover_id(i_recover_id),
    .i_release_valid(i_release_valid),
    .o_free_count(o_free_count), .o_ckpt_full(o_ckpt_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Applies one cycle of inputs at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input int rs, input int rt, input int rw,
                       input logic uses, input logic br, input logic cv, input int cf,
                       input logic rv, input int rid, input logic rel);
    @(negedge clk);
    i_ren_valid     = v;
    i_rs            = 5'(rs);
    i_rt            = 5'(rt);
    i_rw            = 5'(rw);
    i_uses_rw       = uses;
    i_is_branch     = br;
    i_commit_valid  = cv;
    i_commit_free   = 6'(cf);
    i_recover_valid = rv;
    i_recover_id    = 2'(rid);
    i_release_valid = rel;
    #1;
  endtask

  task automatic ren(input int rs, input int rt, input int rw);
    drive(1, rs, rt, rw, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int rs, input int rt);
    drive(0, rs, rt, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle(0, 0);
    do_reset();

    // Reset state and basic allocation
    idle(9, 0);
    chk("rst_count", 32'(o_free_count), 32);
    chk("rst_full", 32'(o_ckpt_full), 0);
    chk("rst_map9", 32'(o_rs_phys), 9);
    chk("rst_ready", 32'(o_ren_ready), 1);
    ren(0, 0, 5);
    chk("a_ready", 32'(o_ren_ready), 1);
    chk("a_rw_phys", 32'(o_rw_phys), 32);
    chk("a_old_rw", 32'(o_old_rw_phys), 5);
    ren(5, 0, 6);
    chk("a_rs_new", 32'(o_rs_phys), 32);
    chk("a_rw_phys2", 32'(o_rw_phys), 33);
    chk("a_count31", 32'(o_free_count), 31);
    ren(7, 7, 7);
    chk("a_rs_eq_rw", 32'(o_rs_phys), 7);
    chk("a_rt_eq_rw", 32'(o_rt_phys), 7);
    chk("a_rw_phys3", 32'(o_rw_phys), 34);
    chk("a_count30", 32'(o_free_count), 30);
    ren(0, 0, 0);
    chk("r0_rw_phys", 32'(o_rw_phys), 0);
    chk("r0_old", 32'(o_old_rw_phys), 0);
    chk("r0_ready", 32'(o_ren_ready), 1);
    idle(0, 0);
    chk("r0_count", 32'(o_free_count), 29);

    // Checkpoint and recovery
    do_reset();
    ren(0, 0, 1);
    ren(0, 0, 2);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("b_br_ready", 32'(o_ren_ready), 1);
    chk("b_br_id", 32'(o_ckpt_id), 0);
    chk("b_br_count", 32'(o_free_count), 30);
    ren(0, 0, 3);
    chk("b_rw3_a", 32'(o_rw_phys), 34);
    ren(0, 0, 3);
    ren(0, 0, 3);
    chk("b_rw3_c", 32'(o_rw_phys), 36);
    chk("b_old3_c", 32'(o_old_rw_phys), 35);
    idle(3, 0);
    chk("b_map3", 32'(o_rs_phys), 36);
    chk("b_count27", 32'(o_free_count), 27);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0);
    chk("b_rec_ready", 32'(o_ren_ready), 0);
    idle(3, 1);
    chk("b_rec_map3", 32'(o_rs_phys), 3);
    chk("b_rec_map1", 32'(o_rt_phys), 32);
    chk("b_rec_count", 32'(o_free_count), 30);
    chk("b_rec_tail", 32'(o_ckpt_id), 1);
    ren(0, 0, 3);
    chk("b_realloc", 32'(o_rw_phys), 34);

    // Free-list exhaustion and refill
    do_reset();
    for (int i = 0; i < 32; i++) ren(0, 0, (i % 31) + 1);
    idle(0, 0);
    chk("c_count0", 32'(o_free_count), 0);
    drive(1, 0, 0, 1, 1, 0, 1, 7, 0, 0, 0);
    chk("c_stall", 32'(o_ren_ready), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("c_nodst_ready", 32'(o_ren_ready), 1);
    chk("c_count1", 32'(o_free_count), 1);
    ren(0, 0, 2);
    chk("c_refill_rdy", 32'(o_ren_ready), 1);
    chk("c_refill_phys", 32'(o_rw_phys), 7);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0, 0);
    chk("c_free0_ign", 32'(o_free_count), 0);

    // Checkpoint capacity, release and recovery into wrapped slots
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("d_br_id", 32'(o_ckpt_id), 32'(i));
    end
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("d_full", 32'(o_ckpt_full), 1);
    chk("d_full_stall", 32'(o_ren_ready), 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("d_rel_stall", 32'(o_ren_ready), 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("d_after_rel", 32'(o_ckpt_full), 0);
    chk("d_accept", 32'(o_ren_ready), 1);
    chk("d_wrap_id", 32'(o_ckpt_id), 0);
    idle(0, 0);
    chk("d_full_again", 32'(o_ckpt_full), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    idle(0, 0);
    chk("d_rec_full", 32'(o_ckpt_full), 0);
    chk("d_rec_tail", 32'(o_ckpt_id), 3);

    // Concurrent rename/commit and recover/rename/commit
    do_reset();
    for (int i = 0; i < 22; i++) ren(0, 0, i + 1);
    drive(1, 0, 0, 4, 1, 0, 1, 40, 0, 0, 0);
    chk("e_ready", 32'(o_ren_ready), 1);
    chk("e_rw_phys", 32'(o_rw_phys), 54);
    chk("e_old_rw", 32'(o_old_rw_phys), 35);
    chk("e_count_pre", 32'(o_free_count), 10);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("e_count_post", 32'(o_free_count), 10);
    chk("e_br_id", 32'(o_ckpt_id), 0);
    drive(1, 0, 0, 4, 1, 0, 1, 41, 1, 0, 0);
    chk("e_rec_ready", 32'(o_ren_ready), 0);
    idle(4, 0);
    chk("e_map4", 32'(o_rs_phys), 54);
    chk("e_rec_commit", 32'(o_free_count), 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_map_unit.md
RENAME_MAP_UNIT -- requirements
Module: rename_map_unit

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32, number of architectural registers.
REQ-002 SHALL have parameter PHYS_REGS, default 64, number of physical registers; PHYS_REGS > ARCH_REGS.
REQ-003 SHALL have parameter CKPT_DEPTH, default 4, number of branch map checkpoints.
REQ-004 SHALL have ports (AW=$clog2(ARCH_REGS), PW=$clog2(PHYS_REGS), CW=$clog2(CKPT_DEPTH)):
  clk  in  1  clock, one clock domain;
  rst_n  in  1  reset, synchronous, active-low;
  i_ren_valid  in  1  rename request;
  o_ren_ready  out  1  request accepted this cycle when high with valid;
  i_rs, i_rt, i_rw  in  AW each  architectural sources/destination;
  i_uses_rw  in  1  instruction writes i_rw;
  i_is_branch  in  1  take checkpoint;
  o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys  out  PW each  rename results;
  o_ckpt_id  out  CW  checkpoint slot taken;
  i_commit_valid  in  1  retire;  i_commit_free  in  PW  old mapping to recycle;
  i_recover_valid  in  1  mispredict;  i_recover_id  in  CW  checkpoint to restore;
  i_release_valid  in  1  oldest branch resolved correct;
  o_free_count  out  PW+1  free physical registers;
  o_ckpt_full  out  1  all checkpoints in use.

Function
REQ-005 SHALL look up o_rs_phys/o_rt_phys combinationally from the current map (zero latency); map/free-list updates take effect the cycle after acceptance.
REQ-006 SHALL treat allocation as needed when i_uses_rw=1 and i_rw!=0; r0 SHALL always map to phys 0 and never be renamed.
REQ-007 SHALL drive o_ren_ready = !i_recover_valid && (!alloc_needed || free_count>0) && (!i_is_branch || !o_ckpt_full); same-cycle commit SHALL NOT count toward readiness.
REQ-008 On accepted allocation: o_rw_phys = free-list head, o_old_rw_phys = prior map[i_rw], map[i_rw] <= head, head advances mod (PHYS_REGS-ARCH_REGS+... ) circular, count decrements.
REQ-009 Without allocation: o_rw_phys = o_old_rw_phys = map[i_rw].
REQ-010 Source lookup SHALL use map before the same instruction's destination update (i_rs==i_rw returns old mapping).
REQ-011 Accepted branch SHALL snapshot map (including its own destination update) and free-list head into slot tail, output o_ckpt_id=tail, tail advances mod CKPT_DEPTH.
REQ-012 i_commit_valid SHALL append i_commit_free at free-list tail; i_commit_free=0 SHALL be ignored.
REQ-013 i_recover_valid SHALL restore map and free-list head from slot i_recover_id, set checkpoint tail to i_recover_id+1, discard younger slots; count recomputed from head/tail.
REQ-014 i_release_valid SHALL free the oldest checkpoint slot (in-order); ignored when no slot in use.
REQ-015 Free list SHALL be a circular FIFO of depth PHYS_REGS, pointers PW+1 bits with wrap bit; full/empty distinguished by wrap bit.
REQ-016 Simultaneous rename+commit: both apply; count = count - alloc + free.
REQ-017 Simultaneous recover+commit: recovery restores head, commit still appends at tail.
REQ-018 Simultaneous recover+release: recover applies first; release ignored if it targets a discarded slot.
REQ-019 Simultaneous branch-rename+release at CKPT full: rename stalls this cycle (REQ-007 uses registered full).

Reset
REQ-020 While rst_n=0 at clk edge: map[i]=i; free list holds ARCH_REGS..PHYS_REGS-1 in order, head=0, count=PHYS_REGS-ARCH_REGS; all checkpoints free; o_ckpt_full=0.
REQ-021 Reset mid-operation SHALL discard all in-flight renames and checkpoints; outputs valid per REQ-020 the following cycle.

Structure
REQ-022 Package rename_pkg SHALL hold default parameters, phys_reg_t/arch_reg_t/ckpt_id_t typedefs and the map-table struct.
REQ-023 Free-list FIFO SHALL be sub-module rename_free_list (push, pop, head restore, count).

Verification
REQ-024 Reset, rename rw=5 -> o_rw_phys=32, o_old_rw_phys=5; next rename rs=5 -> o_rs_phys=32.
REQ-025 32 renames rw=1..31 cycling with no commit -> o_free_count=0, o_ren_ready=0; one commit free=7 -> ready=1 next cycle, next o_rw_phys=7.
REQ-026 Branch at free_count=30 (ckpt 0), three renames rw=3, recover id 0 -> map[3] restored, o_free_count=30.
REQ-027 Four branches without release -> o_ckpt_full=1, fifth branch ready=0; release -> accepted with o_ckpt_id=0.
REQ-028 Same cycle rename rw=4 + commit free=40 at count=10 -> count=10; recover+rename same cycle -> ready=0, map unchanged by rename.
REQ-029 Rename rw=0 uses_rw=1 -> o_rw_phys=0, free_count unchanged.
